// File: rtl/rom_read_arbiter_if.sv
// Requester-side bus of rom_read_arbiter: per-requester req/ack handshake,
// packed addresses and read data, plus the ready flag.
interface rom_read_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    ack;
  logic [NREQ*DW-1:0] rdata;
  logic               ready;

  modport master (output req, output req_addr, input ack, input rdata, input ready);
  modport slave  (input req, input req_addr, output ack, output rdata, output ready);
endinterface

// File: rtl/rom_read_arbiter.sv
// Sequences the ROM load pass after reset, then round-robin shares the two
// ROM read ports among NREQ requesters (up to two grants per cycle).
module rom_read_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rom_read_arbiter_if.slave bus,
  output logic          o_rom_wr_en,
  output logic          o_rom_port_en_0,
  output logic          o_rom_port_en_1,
  output logic [AW-1:0] o_rom_addr_0,
  output logic [AW-1:0] o_rom_addr_1,
  input  logic [DW-1:0] i_rom_data_0,
  input  logic [DW-1:0] i_rom_data_1
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        r_state;
  logic [4:0]    r_cnt;
  logic [IW-1:0] r_ptr;
  logic          r_ready;
  logic          r_wr_en;
  logic          r_en0, r_en1;
  logic [AW-1:0] r_addr0, r_addr1;
  logic [IW-1:0] r_own0, r_own1;
  logic          r_ack   [NREQ];
  logic [DW-1:0] r_rdata [NREQ];

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_issued;
  logic            w_cap0, w_cap1;
  logic            w_win0_vld, w_win1_vld;
  logic [IW-1:0]   w_win0, w_win1;
  logic [IW:0]     w_idx;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (v == IW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Port 0 is also used by the load pass; only read-issued cycles are captured.
  assign w_cap0 = r_en0 & ~r_wr_en;
  assign w_cap1 = r_en1;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_issued[gi] = (w_cap0 && r_own0 == IW'(gi)) || (w_cap1 && r_own1 == IW'(gi));
      assign w_elig[gi]   = bus.req[gi] & ~r_ack[gi] & ~w_issued[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ack[gi]   <= 1'b0;
          r_rdata[gi] <= '0;
        end else begin
          r_ack[gi] <= 1'b0;
          if (w_cap0 && r_own0 == IW'(gi)) begin
            r_ack[gi]   <= 1'b1;
            r_rdata[gi] <= i_rom_data_0;
          end else if (w_cap1 && r_own1 == IW'(gi)) begin
            r_ack[gi]   <= 1'b1;
            r_rdata[gi] <= i_rom_data_1;
          end
        end
      end

      assign bus.ack[gi]               = r_ack[gi];
      assign bus.rdata[gi*DW +: DW]    = r_rdata[gi];
    end
  endgenerate

  // Round-robin scan from r_ptr: first eligible takes port 0, second port 1.
  always_comb begin
    w_win0_vld = 1'b0;
    w_win1_vld = 1'b0;
    w_win0     = '0;
    w_win1     = '0;
    w_idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NREQ)) w_idx = w_idx - (IW+1)'(NREQ);
      if (w_elig[w_idx[IW-1:0]]) begin
        if (!w_win0_vld) begin
          w_win0_vld = 1'b1;
          w_win0     = w_idx[IW-1:0];
        end else if (!w_win1_vld) begin
          w_win1_vld = 1'b1;
          w_win1     = w_idx[IW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_ready <= 1'b0;
      r_wr_en <= 1'b0;
      r_en0   <= 1'b0;
      r_en1   <= 1'b0;
      r_addr0 <= '0;
      r_addr1 <= '0;
      r_own0  <= '0;
      r_own1  <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_en1   <= 1'b0;
          r_addr1 <= '0;
          if (r_cnt != 5'd16) begin
            r_wr_en <= 1'b1;
            r_en0   <= 1'b1;
            r_addr0 <= r_cnt[AW-1:0];
            r_cnt   <= r_cnt + 5'd1;
          end else begin
            // Settle cycle: all ROM controls idle before reads begin.
            r_wr_en <= 1'b0;
            r_en0   <= 1'b0;
            r_addr0 <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
          r_wr_en <= 1'b0;
          r_en0   <= w_win0_vld;
          r_en1   <= w_win1_vld;
          r_own0  <= w_win0;
          r_own1  <= w_win1;
          r_addr0 <= w_win0_vld ? bus.req_addr[w_win0*AW +: AW] : '0;
          r_addr1 <= w_win1_vld ? bus.req_addr[w_win1*AW +: AW] : '0;
          if (w_win1_vld)      r_ptr <= inc_wrap(w_win1);
          else if (w_win0_vld) r_ptr <= inc_wrap(w_win0);
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign bus.ready       = r_ready;
  assign o_rom_wr_en     = r_wr_en;
  assign o_rom_port_en_0 = r_en0;
  assign o_rom_port_en_1 = r_en1;
  assign o_rom_addr_0    = r_addr0;
  assign o_rom_addr_1    = r_addr1;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: load pass, single/paired reads,
// fairness, ack masking and mid-flight reset, against a small ROM model.
module tb_rom_read_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_read_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) arb_if ();

  logic          wr_en, en0, en1;
  logic [AW-1:0] a0, a1;
  wire  [DW-1:0] d0, d1;
  logic [DW-1:0] rom_mem [16];

  // ROM model: combinational read, high-Z when the port is disabled.
  assign d0 = en0 ? rom_mem[a0] : 'z;
  assign d1 = en1 ? rom_mem[a1] : 'z;

  rom_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (arb_if),
    .o_rom_wr_en     (wr_en),
    .o_rom_port_en_0 (en0),
    .o_rom_port_en_1 (en1),
    .o_rom_addr_0    (a0),
    .o_rom_addr_1    (a1),
    .i_rom_data_0    (d0),
    .i_rom_data_1    (d1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s = %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return arb_if.rdata[i*DW +: DW];
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a);
    arb_if.req[i]            = v;
    arb_if.req_addr[i*AW +: AW] = a;
  endtask

  // Expects to be called at a falling edge right after reset release.
  task automatic load_pass(input string tag);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check({tag, "_load"}, {24'd0, wr_en, en0, en1, arb_if.ready, a0}, {24'd0, 4'b1100, 4'(c)});
    end
    @(negedge clk);
    check({tag, "_settle"}, {28'd0, wr_en, en0, en1, arb_if.ready}, 32'd0);
    @(negedge clk);
    check({tag, "_ready"}, {30'd0, arb_if.ready, wr_en}, 32'b10);
  endtask

  int cnt0, cnt1, ack3_at, diff;
  logic [DW-1:0] d3;

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'(8'h31 + i * 7);
    rom_mem[0]  = 8'h24;
    rom_mem[1]  = 8'h5B;
    rom_mem[2]  = 8'hE2;
    rom_mem[5]  = 8'hAE;
    rom_mem[8]  = 8'hA3;
    rom_mem[10] = 8'hEC;
    arb_if.req      = '0;
    arb_if.req_addr = '0;

    repeat (2) @(negedge clk);
    check("rst_ctrl",  {19'd0, wr_en, en0, en1, a0, a1, arb_if.ready}, 32'd0);
    check("rst_ack",   32'(arb_if.ack), 32'd0);
    check("rst_rdata", arb_if.rdata, 32'd0);
    rst_n = 1'b1;
    load_pass("boot");

    // Single request from requester 2, address 5.
    set_req(2, 1'b1, 4'd5);
    @(negedge clk);
    check("single_issue", {26'd0, en0, en1, a0}, {26'd0, 2'b10, 4'd5});
    check("single_noack", 32'(arb_if.ack), 32'd0);
    @(negedge clk);
    check("single_ack",  32'(arb_if.ack), 32'b0100);
    check("single_data", 32'(rd(2)), 32'hAE);
    set_req(2, 1'b0, 4'd0);
    @(negedge clk);
    check("single_ackdrop", 32'(arb_if.ack), 32'd0);
    check("single_hold",    32'(rd(2)), 32'hAE);

    // Requester 3 alone moves the pointer back to 0.
    set_req(3, 1'b1, 4'd1);
    repeat (2) @(negedge clk);
    check("r3_ack",  32'(arb_if.ack), 32'b1000);
    check("r3_data", 32'(rd(3)), 32'h5B);
    set_req(3, 1'b0, 4'd0);
    @(negedge clk);

    // All four requesters at once, pointer at 0.
    set_req(0, 1'b1, 4'd0);
    set_req(1, 1'b1, 4'd2);
    set_req(2, 1'b1, 4'd8);
    set_req(3, 1'b1, 4'd10);
    @(negedge clk);
    check("all_issueA", {22'd0, en0, en1, a0, a1}, {22'd0, 2'b11, 4'd0, 4'd2});
    check("all_noack",  32'(arb_if.ack), 32'd0);
    @(negedge clk);
    check("all_issueB", {22'd0, en0, en1, a0, a1}, {22'd0, 2'b11, 4'd8, 4'd10});
    check("all_ackA",   32'(arb_if.ack), 32'b0011);
    check("all_d0",     32'(rd(0)), 32'h24);
    check("all_d1",     32'(rd(1)), 32'hE2);
    set_req(0, 1'b0, 4'd0);
    set_req(1, 1'b0, 4'd0);
    @(negedge clk);
    check("all_ackB",  32'(arb_if.ack), 32'b1100);
    check("all_d2",    32'(rd(2)), 32'hA3);
    check("all_d3",    32'(rd(3)), 32'hEC);
    check("all_idle",  {30'd0, en0, en1}, 32'd0);
    set_req(2, 1'b0, 4'd0);
    set_req(3, 1'b0, 4'd0);
    repeat (2) @(negedge clk);

    // Fairness: 0 and 1 hold req, 3 requests once.
    cnt0 = 0; cnt1 = 0; ack3_at = 0; d3 = '0;
    set_req(0, 1'b1, 4'd0);
    set_req(1, 1'b1, 4'd2);
    set_req(3, 1'b1, 4'd5);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (arb_if.ack[0]) cnt0++;
      if (arb_if.ack[1]) cnt1++;
      if (arb_if.ack[3] && ack3_at == 0) begin
        ack3_at = k;
        d3 = rd(3);
        set_req(3, 1'b0, 4'd0);
      end
    end
    diff = (cnt0 > cnt1) ? cnt0 - cnt1 : cnt1 - cnt0;
    check("fair_r3_cycle", 32'(ack3_at), 32'd3);
    check("fair_r3_data",  32'(d3), 32'hAE);
    check("fair_cnt0",     32'(cnt0), 32'd10);
    check("fair_cnt1",     32'(cnt1), 32'd10);
    check("fair_diff_le1", 32'(diff <= 1), 32'd1);
    arb_if.req = '0;
    repeat (3) @(negedge clk);

    // Requester 1 holds req through its ack: one ack every third cycle.
    set_req(1, 1'b1, 4'd3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("nodbl_c%0d", k), 32'(arb_if.ack), (k % 3 == 2) ? 32'b0010 : 32'd0);
    end
    set_req(1, 1'b0, 4'd0);
    repeat (3) @(negedge clk);

    // Reset one cycle after a grant: no ack, outputs cleared, load pass replays.
    set_req(0, 1'b1, 4'd5);
    @(negedge clk);
    check("mf_grant", {27'd0, en0, a0}, {27'd0, 1'b1, 4'd5});
    rst_n = 1'b0;
    #1;
    check("mf_ctrl",  {19'd0, wr_en, en0, en1, a0, a1, arb_if.ready}, 32'd0);
    check("mf_rdata", arb_if.rdata, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mf_noack", 32'(arb_if.ack), 32'd0);
    end
    set_req(0, 1'b0, 4'd0);
    rst_n = 1'b1;
    load_pass("replay");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Controller and round-robin arbiter sitting in front of the `dual_port_rom` block. After reset it sequences the ROM's load pass over all 16 locations, then shares the ROM's two read ports among NREQ requesters, granting up to two requests per cycle. Each requester uses a simple req/ack handshake and receives its data in a registered per-requester data register.

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- AW, 4: ROM address width; fixed at 4 (16 words).
- DW, 8: ROM data width.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- req_addr  in  NREQ*AW  requester i's address in bits [i*AW +: AW]; held stable while req[i]=1.
- ack  out  NREQ  one-cycle pulse per completed request.
- rdata  out  NREQ*DW  requester i's read data in bits [i*DW +: DW]; valid while ack[i]=1, then held.
- ready  out  1  high once the ROM load pass is complete.
- rom_wr_en  out  1  drives the ROM wr_en input.
- rom_port_en_0, rom_port_en_1  out  1 each  drive the ROM port enables.
- rom_addr_0, rom_addr_1  out  AW each  drive the ROM addresses.
- rom_data_0, rom_data_1  in  DW each  ROM data outputs. These are high-Z when the corresponding port is disabled.

## Operation
- FSM states: INIT, RUN.
- INIT is entered on reset. It uses a 5-bit counter cnt that runs 0..16.
  - For cnt 0..15: rom_wr_en=1, rom_port_en_0=1, rom_addr_0=cnt.
  - For cnt=16: all ROM controls are 0; this is a settle cycle.
  - When cnt=16, the FSM moves to RUN and ready rises.
- RUN is terminal until reset. In RUN, rom_wr_en=0 at all times.
- Eligibility: requester i is eligible when req[i]=1, it is not issued in the current issue stage, and ack[i]=0. This masking prevents a stale req from being granted twice.
- Arbitration (every RUN cycle):
  - Scan requesters starting at round-robin pointer ptr and wrapping modulo NREQ.
  - The first eligible requester wins port 0; the second eligible requester wins port 1.
  - If there are fewer than two winners, the unused port gets port_en=0.
  - After any grant, ptr becomes (last winner index + 1) mod NREQ. If nothing is granted, ptr is unchanged.
  - ptr resets to 0.
- Issue stage (registered): holds rom_port_en_x, rom_addr_x (the winner's req_addr) and owner_x (the winner's index).
- Capture stage: for each issued port x, at the next edge rdata[owner_x] <= rom_data_x and ack[owner_x] <= 1. Ack lasts one cycle.
- Data is captured only from an issued port; a disabled (Z) port is never sampled.
- The two ports always serve different requesters, so there are never two acks to the same requester in one cycle.

## Timing
- Reset values:
  - State INIT, cnt=0, ptr=0.
  - ready=0, ack=0, rdata=0.
  - rom_wr_en=0, rom_port_en_0=0, rom_port_en_1=0, rom_addr_0=0, rom_addr_1=0.
- Load pass: the first cycle after reset release has cnt=0. ready is 1 starting 17 cycles after that first cycle.
- Request latency:
  - req sampled at edge E0 → issue registers loaded at E0.
  - ROM read happens combinationally during cycle E0..E1.
  - E1 loads rdata and ack → ack is high in cycle E1..E2.
  - Request-to-ack latency is 2 edges.
- Handshake: the requester must drop req, or present a new address, in the cycle ack is high. Because of masking, req is re-sampled for a new grant no earlier than E3. Maximum rate is one request per requester every 3 cycles.
- Aggregate throughput: 2 reads per cycle.
- Requests during INIT are held pending (not lost) and are arbitrated from the first RUN cycle onward.
- Asynchronous reset mid-operation:
  - All in-flight requests are dropped with no ack.
  - Outputs return immediately to their reset values.
  - The load pass restarts.

## Test plan
- Reset release: rom_wr_en=1 and rom_addr_0 steps 0..15 over 16 cycles, followed by 1 settle cycle. ready=1 on the 18th cycle. A ROM read then returns 0x24 for address 0.
- Single request: req[2]=1 with addr 5 → rom_addr_0=5 one edge later, then ack[2] pulses with rdata[2]=0xAE two edges after sampling.
- Simultaneous requests: all 4 req=1 with ptr=0 (addrs 0, 2, 8, 10):
  - First cycle: requesters 0 and 1 issued (data 0x24, 0xE2).
  - Next cycle: requesters 2 and 3 issued (data 0xA3, 0xEC).
  - Acks arrive in the same pairs.
- Fairness: requesters 0 and 1 hold req continuously while requester 3 requests once → requester 3 is acked within 2 grant cycles. Grant counts for requesters 0 and 1 differ by at most 1 over 30 cycles.
- No double grant: requester 1 holds req through its ack → exactly one ack per 3-cycle window, never two consecutive acks.
- Reset mid-flight: assert rst_n=0 one cycle after a grant → no ack, all outputs at their reset values, and the INIT sequence replays.
